// File: rtl/jb_dbgmux_capture_ctrl_if.sv
// rtl/jb_dbgmux_capture_ctrl_if.sv - control, sample-stream and buffer port A signals of the capture controller
interface jb_dbgmux_capture_ctrl_if #(
  parameter int AW      = 18,
  parameter int DW      = 64,
  parameter int NUM_COL = 8
);
  logic               arm;
  logic               abort;
  logic [AW-1:0]      cfg_depth;
  logic [AW-1:0]      cfg_pre;
  logic [AW-1:0]      cfg_post;
  logic               smp_vld;
  logic [DW-1:0]      smp_data;
  logic               trig;
  logic               ena;
  logic [NUM_COL-1:0] wea;
  logic [19:0]        addra;
  logic [DW-1:0]      dina;
  logic               busy;
  logic               done;
  logic               wrapped;
  logic [AW-1:0]      trig_addr;
  logic [AW-1:0]      wr_ptr;

  modport master (
    output arm, abort, cfg_depth, cfg_pre, cfg_post, smp_vld, smp_data, trig,
    input  ena, wea, addra, dina, busy, done, wrapped, trig_addr, wr_ptr
  );

  modport slave (
    input  arm, abort, cfg_depth, cfg_pre, cfg_post, smp_vld, smp_data, trig,
    output ena, wea, addra, dina, busy, done, wrapped, trig_addr, wr_ptr
  );
endinterface

// File: rtl/jb_dbgmux_capture_ctrl.sv
// rtl/jb_dbgmux_capture_ctrl.sv - pre/post-trigger capture controller writing a circular window into the debug buffer
module jb_dbgmux_capture_ctrl #(
  parameter int AW      = 18,
  parameter int DW      = 64,
  parameter int NUM_COL = 8
) (
  input logic                     clk,
  input logic                     rst,
  jb_dbgmux_capture_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] depth_q, depth_d, pre_q, pre_d, post_q, post_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d;
  logic          wrapped_q, wrapped_d;
  logic          ena_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dina_q;
  logic          accept;
  logic [AW-1:0] pre_eff;
  logic [AW-1:0] last_addr;

  // depth_q==0 encodes 2**AW, so depth_q-1 wraps naturally to the top address
  assign last_addr = depth_q - AW'(1);

  always_comb begin
    pre_eff = bus.cfg_pre;
    if (bus.cfg_depth != '0 && bus.cfg_pre >= bus.cfg_depth) pre_eff = bus.cfg_depth - AW'(1);
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    pre_d       = pre_q;
    post_d      = post_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    wrapped_d   = wrapped_q;
    accept      = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            depth_d     = bus.cfg_depth;
            pre_d       = pre_eff;
            post_d      = bus.cfg_post;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            pre_cnt_d   = '0;
            trig_addr_d = '0;
            state_d     = (pre_eff == '0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          if (bus.smp_vld) begin
            accept    = 1'b1;
            pre_cnt_d = pre_cnt_q + AW'(1);
            if (pre_cnt_d == pre_q) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.smp_vld) begin
            accept = 1'b1;
            if (bus.trig) begin
              trig_addr_d = wr_ptr_q;
              post_cnt_d  = '0;
              state_d     = (post_q == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (bus.smp_vld) begin
            accept     = 1'b1;
            post_cnt_d = post_cnt_q + AW'(1);
            if (post_cnt_d == post_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (accept) begin
      if (wr_ptr_q == last_addr) begin
        wr_ptr_d  = '0;
        wrapped_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      wrapped_q   <= 1'b0;
      ena_q       <= 1'b0;
      addr_q      <= '0;
      dina_q      <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      wrapped_q   <= wrapped_d;
      ena_q       <= accept;
      if (accept) begin
        addr_q <= wr_ptr_q;
        dina_q <= bus.smp_data;
      end
    end
  end

  assign bus.ena       = ena_q;
  assign bus.wea       = {NUM_COL{ena_q}};
  assign bus.addra     = 20'(addr_q);
  assign bus.dina      = dina_q;
  assign bus.busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign bus.done      = (state_q == S_DONE);
  assign bus.wrapped   = wrapped_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.wr_ptr    = wr_ptr_q;
endmodule
